// File: rtl/mux_serializer.sv
// Parallel-to-serial vector streamer: captures a DIM-element signed vector and emits
// L elements one per handshake, ascending or descending, with zero-bubble reload.
module mux_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIM       = 8,
  parameter int unsigned SEL_WIDTH = $clog2(DIM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     in [DIM],
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        dir_in,
  input  logic        [SEL_WIDTH:0]   len_in,
  output logic signed [WIDTH-1:0]     out_data,
  output logic        [SEL_WIDTH-1:0] out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam logic [SEL_WIDTH:0]   DimLen = (SEL_WIDTH+1)'(DIM);
  localparam logic [SEL_WIDTH:0]   LenOne = (SEL_WIDTH+1)'(1);
  localparam logic [SEL_WIDTH-1:0] IdxOne = SEL_WIDTH'(1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                     state_q, state_d;
  logic signed [WIDTH-1:0]    data_q [DIM];
  logic signed [WIDTH-1:0]    data_d [DIM];
  logic                       dir_q, dir_d;
  logic        [SEL_WIDTH-1:0] end_idx_q, end_idx_d;
  logic        [SEL_WIDTH-1:0] out_idx_q, out_idx_d;
  logic signed [WIDTH-1:0]    out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;

  logic                       accept, handshake;
  logic        [SEL_WIDTH:0]   eff_len;
  logic        [SEL_WIDTH-1:0] first_idx, last_idx, next_idx;

  assign in_ready  = !rst && ((state_q == StIdle) || (out_valid_q && out_ready && out_last_q));
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  // A zero or oversized length means "the whole vector".
  assign eff_len   = ((len_in == '0) || (len_in > DimLen)) ? DimLen : len_in;
  assign first_idx = dir_in ? SEL_WIDTH'(eff_len - LenOne) : '0;
  assign last_idx  = dir_in ? '0 : SEL_WIDTH'(eff_len - LenOne);
  assign next_idx  = dir_q ? (out_idx_q - IdxOne) : (out_idx_q + IdxOne);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    end_idx_d   = end_idx_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    // Accept only happens in STREAM together with the last handshake, so it takes priority.
    if (accept) begin
      state_d     = StStream;
      data_d      = in;
      dir_d       = dir_in;
      end_idx_d   = last_idx;
      out_idx_d   = first_idx;
      out_data_d  = in[first_idx];
      out_valid_d = 1'b1;
      out_last_d  = (eff_len == LenOne);
    end else if (handshake) begin
      if (out_last_q) begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_idx_d  = next_idx;
        out_data_d = data_q[next_idx];
        out_last_d = (next_idx == end_idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int k = 0; k < DIM; k++) begin
        data_q[k] <= '0;
      end
      dir_q       <= 1'b0;
      end_idx_q   <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      end_idx_q   <= end_idx_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer: accepted vectors expand into expected element
// sequences; a negedge monitor checks every presented element and the handshake flags.
module tb_mux_serializer;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int SW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [W-1:0]  in_vec [D];
  logic                 in_valid;
  logic                 in_ready;
  logic                 dir_in;
  logic [SW:0]          len_in;
  logic signed [W-1:0]  out_data;
  logic [SW-1:0]        out_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rst_prev = 1'b0;
  bit   ready_rand = 1'b0;

  mux_serializer #(.WIDTH(W), .DIM(D), .SEL_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dir_in    (dir_in),
    .len_in    (len_in),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expand an accepted vector into the element order it must produce.
  task automatic push_expected();
    int l;
    int id;
    exp_t e;
    l = (len_in == 0 || len_in > D) ? D : int'(len_in);
    for (int j = 0; j < l; j++) begin
      id     = dir_in ? (l - 1 - j) : j;
      e.data = int'(in_vec[id]);
      e.idx  = id;
      e.last = (j == l - 1);
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: mid-cycle, everything is stable for the upcoming edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", int'(in_ready), 0);
      if (rst_prev) begin
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_data", int'(out_data), 0);
      end
      q.delete();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("in_ready", int'(in_ready),
            int'((q.size() == 0) || (out_ready && q.size() == 1)));
      check("out_valid", int'(out_valid), int'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("out_data", int'(out_data), q[0].data);
        check("out_idx", int'(out_idx), q[0].idx);
        check("out_last", int'(out_last), int'(q[0].last));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) push_expected();
    end
  end

  task automatic send(input bit dir, input int len);
    bit ok = 1'b0;
    dir_in   = dir;
    len_in   = (SW+1)'(len);
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: in_ready never rose within 200 cycles");
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic ramp_vector();
    for (int k = 0; k < D; k++) in_vec[k] = W'(k * 10 - 35);
  endtask

  task automatic random_vector();
    for (int k = 0; k < D; k++) in_vec[k] = W'($urandom);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: %0d elements still pending", q.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dir_in    = 1'b0;
    len_in    = '0;
    out_ready = 1'b1;
    ramp_vector();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Full ascending ramp, then a short descending slice.
    send(1'b0, 0);
    drain();
    send(1'b1, 3);
    drain();

    // Oversized and single-element lengths.
    send(1'b0, 12);
    drain();
    send(1'b1, 1);
    drain();

    // Stalls, then back-to-back vectors with in_valid held across the last handshake.
    ready_rand = 1'b1;
    send(1'b0, 0);
    random_vector();
    send(1'b1, 5);
    ramp_vector();
    send(1'b0, 2);
    drain();
    ready_rand = 1'b0;

    // Reset in the middle of an 8-element stream.
    send(1'b0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(1'b0, 4);
    drain();

    // Randomized traffic.
    ready_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      random_vector();
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_serializer.md
MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the element width in bits; elements are signed.
REQ-002 SHALL have parameter DIM, default 8, meaning the number of elements per vector (DIM >= 2).
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(DIM), meaning the width of the index and length fields.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in  input  DIM x WIDTH signed  parallel vector, element k at in[k].
REQ-007 in_valid  input  1  vector, dir_in and len_in are valid.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 dir_in  input  1  0 = ascending order, 1 = descending order.
REQ-010 len_in  input  SEL_WIDTH+1  number of elements to emit.
REQ-011 out_data  output  WIDTH signed  selected element.
REQ-012 out_idx  output  SEL_WIDTH  source index of out_data.
REQ-013 out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-014 out_ready  input  1  downstream consumes the element.
REQ-015 out_last  output  1  current element is the final element of the vector.

Function
REQ-016 SHALL implement states IDLE and STREAM.
REQ-017 in_ready SHALL equal (state==IDLE) OR (out_valid AND out_ready AND out_last).
REQ-018 Accept = in_valid AND in_ready; on accept SHALL register all DIM elements, dir_in and the effective length L.
REQ-019 L SHALL be DIM when len_in is 0 or len_in > DIM; otherwise L SHALL be len_in.
REQ-020 out_valid SHALL assert the cycle after accept (latency 1) and state SHALL be STREAM.
REQ-021 First out_idx SHALL be 0 when ascending and L-1 when descending.
REQ-022 out_data SHALL equal the registered element at out_idx.
REQ-023 out_data, out_idx and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On handshake (out_valid AND out_ready) with out_last=0, out_idx SHALL step +1 (ascending) or -1 (descending) on the next cycle.
REQ-025 out_last SHALL be 1 exactly on the L-th element emitted.
REQ-026 On last handshake with no simultaneous accept, next state SHALL be IDLE and out_valid SHALL be 0.
REQ-027 On last handshake with simultaneous accept, the new vector SHALL load and its first element SHALL be valid on the next cycle (zero bubble).
REQ-028 Register contents SHALL not change while in STREAM, except on the accept described in REQ-027.
REQ-029 out_idx SHALL never leave the range 0..DIM-1, with no wrap-around.
REQ-030 L=1 SHALL emit a single element with out_last=1.

Reset
REQ-031 While rst=1, state SHALL be IDLE, out_valid=0, out_last=0, out_idx=0, out_data=0 and in_ready=0; the element registers SHALL clear to 0.
REQ-032 Reset asserted mid-STREAM SHALL abort the vector; no remaining elements SHALL be emitted.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 DIM=8, in[k]=k*10-35, dir=0, len=0, out_ready=1 -> out_data -35,-25,...,35 over 8 consecutive cycles; out_last on idx 7; first out_valid 1 cycle after accept.
REQ-035 Same vector, dir=1, len=3 -> out_idx 2,1,0 with out_data -15,-25,-35; out_last on idx 0; then IDLE.
REQ-036 out_ready toggled 1,0,0,1 during a stream -> out_data, out_idx and out_last held during the stall cycles; no element skipped or duplicated.
REQ-037 Second vector presented with in_valid held through the first vector's last handshake -> second vector's idx 0 is valid on the next cycle, with no gap.
REQ-038 rst pulsed at element 4 of 8 -> out_valid=0 in the following cycle, in_ready=1 after release, and the next vector starts at idx 0.
REQ-039 len_in=12 with DIM=8, and len_in=1 -> 8 elements emitted, and 1 element with out_last=1, respectively.
